id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode/register-file read and the ALU (EX) stage of the 8-bit core.
- Captures register-file operands (read_data1/read_data2), destination, and control bits.
- Applies EX/MEM and MEM/WB forwarding at capture time.
- Detects load-use hazards and inserts bubbles, with a valid/ready handshake on both sides.

Parameters:
- DW, 8, operand/result data width
- AW, 5, register index width (32 entries; index 31 is hard-wired zero)
- OPW, 4, ALU opcode width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_rs, id_rt, id_rd  in  AW each  source and destination indices
- id_uses_rs, id_uses_rt  in  1 each  source operand actually consumed
- id_rdata1, id_rdata2  in  DW each  register-file read data
- id_reg_write, id_mem_read  in  1 each  writeback enable; instruction is a load
- id_alu_op  in  OPW  ALU operation
- exmem_reg_write, exmem_mem_read  in  1 each  EX/MEM stage control
- exmem_rd  in  AW  EX/MEM destination
- exmem_result  in  DW  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writeback enable
- memwb_rd  in  AW  MEM/WB destination
- memwb_result  in  DW  MEM/WB writeback data
- flush  in  1  kill the held instruction and any capture this cycle
- ex_ready  in  1  EX stage can accept
- ex_valid  out  1  held instruction valid
- ex_a, ex_b  out  DW each  forwarded operands
- ex_rd  out  AW  held destination
- ex_reg_write, ex_mem_read  out  1 each  held control
- ex_alu_op  out  OPW  held opcode

Behaviour:
- Reset: on rst=1 at a posedge, all outputs clear to 0 the next cycle. This covers ex_valid, ex_a, ex_b, ex_rd, ex_reg_write, ex_mem_read and ex_alu_op.
- id_ready is combinational: id_ready = advance & ~hazard & ~rst.
  - advance = ex_ready | ~ex_valid.
- Transfer occurs when id_valid & id_ready. All ex_* outputs update 1 cycle after transfer, so latency is 1 cycle.
- Hold: if ex_valid & ~ex_ready, every ex_* output is held unchanged.
- Bubble: if advance & (hazard | ~id_valid), the next ex_valid=0, ex_reg_write=0 and ex_mem_read=0. Data fields are don't-care.
- Hazard (load-use): per used source s (rs if id_uses_rs, rt if id_uses_rt), with s != 31, hazard is raised when either:
  - ex_valid & ex_mem_read & ex_rd == s, or
  - exmem_mem_read & exmem_reg_write & exmem_rd == s.
  - Load-use penalty is exactly 2 bubbles.
- Forwarding per operand (a from rs, b from rt), evaluated in this priority order:
  1. index == 31 → 0. Never forwarded, even if a write to 31 is pending.
  2. exmem_reg_write & ~exmem_mem_read & exmem_rd == index → exmem_result.
  3. memwb_reg_write & memwb_rd == index → memwb_result. This covers the same-cycle register-file write that a combinational read does not yet see.
  4. Otherwise → id_rdataN.
- Unused sources are still forwarded normally; the hazard check ignores them.
- Flush: highest priority after rst.
  - Next ex_valid=0, ex_reg_write=0, ex_mem_read=0, regardless of ex_ready.
  - id_ready is forced to 0 that cycle, so the decode instruction is not consumed.
- Flush and hold in the same cycle: flush wins.
- Reset mid-stall: clears state; no bubble counting persists.
- No internal width arithmetic; all fields are pass-through or muxed at full width.

Optional Feature:
- Macro IDEX_PERF_EN.
- When defined, adds two outputs:
  - stall_cycles, out, 16 bits: counts cycles where id_valid & hazard & advance & ~flush.
  - fwd_count, out, 16 bits: counts transfers where either operand took path 2 or 3.
- Both counters saturate at 16'hFFFF, clear on rst, and increment at most once per cycle.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 → ex_valid=0, all ex_* = 0; id_ready=0 during rst.
- Forwarding priority: id_rs=3, id_rdata1=0x11, exmem_rd=3/result 0x22 (reg_write=1), memwb_rd=3/result 0x33 → ex_a=0x22. Drop exmem_reg_write → 0x33. Drop both → 0x11.
- Register 31: id_rs=31, exmem_rd=31 with reg_write=1 and result 0xAA → ex_a=0x00, no hazard even if ex holds a load to r31.
- Load-use: load rd=5 transfers, next instruction uses rs=5 → id_ready=0 for 2 cycles, ex_valid=0 for 2 cycles. Then transfer with ex_a=memwb_result (0x5C). Same case with id_uses_rs=0 → no stall.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles with changing id_* inputs → ex_* stable, id_ready=0. Raise ex_ready → new instruction captured next cycle.
- Flush: flush=1 while ex_valid=1, ex_ready=0, id_valid=1 → next ex_valid=0, id_ready=0 that cycle. The decode instruction transfers the following cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time forwarding and load-use stall detection.
// Optional perf counters (stall_cycles, fwd_count) are built when IDEX_PERF_EN is defined.
module id_ex_stage #(
    parameter int DW  = 8,
    parameter int AW  = 5,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic [AW-1:0]  id_rd,
    input  logic           id_uses_rs,
    input  logic           id_uses_rt,
    input  logic [DW-1:0]  id_rdata1,
    input  logic [DW-1:0]  id_rdata2,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic [OPW-1:0] id_alu_op,
    input  logic           exmem_reg_write,
    input  logic           exmem_mem_read,
    input  logic [AW-1:0]  exmem_rd,
    input  logic [DW-1:0]  exmem_result,
    input  logic           memwb_reg_write,
    input  logic [AW-1:0]  memwb_rd,
    input  logic [DW-1:0]  memwb_result,
    input  logic           flush,
    input  logic           ex_ready,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [AW-1:0]  ex_rd,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic [OPW-1:0] ex_alu_op
`ifdef IDEX_PERF_EN
    ,
    output logic [15:0]    stall_cycles,
    output logic [15:0]    fwd_count
`endif
);

    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b1}};

    logic           valid_q, valid_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic           reg_write_q, reg_write_d;
    logic           mem_read_q, mem_read_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;

    logic advance, hazard, transfer;
    logic a_from_exmem, a_from_memwb, b_from_exmem, b_from_memwb;
    logic [DW-1:0] fwd_a, fwd_b;

    // A load still in EX, or one in EX/MEM, cannot yet supply its data.
    function automatic logic load_pending(input logic [AW-1:0] idx);
        return (idx != ZERO_IDX) &&
               ((valid_q && mem_read_q && rd_q == idx) ||
                (exmem_mem_read && exmem_reg_write && exmem_rd == idx));
    endfunction

    always_comb begin
        advance  = ex_ready | ~valid_q;
        hazard   = (id_uses_rs && load_pending(id_rs)) ||
                   (id_uses_rt && load_pending(id_rt));
        id_ready = advance & ~hazard & ~rst & ~flush;
        transfer = id_valid & id_ready;
    end

    always_comb begin
        a_from_exmem = (id_rs != ZERO_IDX) && exmem_reg_write && !exmem_mem_read && exmem_rd == id_rs;
        a_from_memwb = (id_rs != ZERO_IDX) && !a_from_exmem && memwb_reg_write && memwb_rd == id_rs;
        b_from_exmem = (id_rt != ZERO_IDX) && exmem_reg_write && !exmem_mem_read && exmem_rd == id_rt;
        b_from_memwb = (id_rt != ZERO_IDX) && !b_from_exmem && memwb_reg_write && memwb_rd == id_rt;

        if (id_rs == ZERO_IDX) fwd_a = '0;
        else if (a_from_exmem) fwd_a = exmem_result;
        else if (a_from_memwb) fwd_a = memwb_result;
        else                   fwd_a = id_rdata1;

        if (id_rt == ZERO_IDX) fwd_b = '0;
        else if (b_from_exmem) fwd_b = exmem_result;
        else if (b_from_memwb) fwd_b = memwb_result;
        else                   fwd_b = id_rdata2;
    end

    always_comb begin
        valid_d     = valid_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        alu_op_d    = alu_op_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (transfer) begin
            valid_d     = 1'b1;
            a_d         = fwd_a;
            b_d         = fwd_b;
            rd_d        = id_rd;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            alu_op_d    = id_alu_op;
        end else if (advance) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alu_op_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            alu_op_q    <= alu_op_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_a         = a_q;
    assign ex_b         = b_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_alu_op    = alu_op_q;

`ifdef IDEX_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] fwd_count_q, fwd_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_count_d    = fwd_count_q;
        if (id_valid && hazard && advance && !flush && stall_cycles_q != 16'hFFFF)
            stall_cycles_d = stall_cycles_q + 16'd1;
        if (transfer && (a_from_exmem || a_from_memwb || b_from_exmem || b_from_memwb) &&
            fwd_count_q != 16'hFFFF)
            fwd_count_d = fwd_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            fwd_count_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_count_q    <= fwd_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_count    = fwd_count_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, r31, load-use,
// backpressure, flush and reset during a stall.
module tb_id_ex_stage;
    localparam int DW = 8, AW = 5, OPW = 4;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_ready;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_rdata1, id_rdata2;
    logic id_reg_write, id_mem_read;
    logic [OPW-1:0] id_alu_op;
    logic exmem_reg_write, exmem_mem_read;
    logic [AW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic memwb_reg_write;
    logic [AW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;
    logic flush, ex_ready, ex_valid;
    logic [DW-1:0] ex_a, ex_b;
    logic [AW-1:0] ex_rd;
    logic ex_reg_write, ex_mem_read;
    logic [OPW-1:0] ex_alu_op;
`ifdef IDEX_PERF_EN
    logic [15:0] stall_cycles, fwd_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_alu_op(id_alu_op),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_alu_op(ex_alu_op)
`ifdef IDEX_PERF_EN
        , .stall_cycles(stall_cycles), .fwd_count(fwd_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic urs, input logic urt,
                         input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic rw, input logic mr, input logic [OPW-1:0] op);
        id_valid = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_rdata1 = d1; id_rdata2 = d2;
        id_reg_write = rw; id_mem_read = mr; id_alu_op = op;
    endtask

    task automatic clear_bypass();
        exmem_reg_write = 1'b0; exmem_mem_read = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        clear_bypass();
        instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 1'b1, 4'hF);

        // Reset held two cycles with a valid decode instruction
        settle();
        chk("rst_id_ready", id_ready, 0);
        tick();
        tick();
        chk("rst_id_ready_2", id_ready, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_b", ex_b, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_ex_ctl", {ex_reg_write, ex_mem_read}, 0);
        chk("rst_ex_alu_op", ex_alu_op, 0);
        rst = 1'b0;

        // Forwarding priority: EX/MEM over MEM/WB over register file
        instr(5'd3, 5'd0, 5'd10, 1'b1, 1'b1, 8'h11, 8'h44, 1'b1, 1'b0, 4'h2);
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 8'h22;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 8'h33;
        settle();
        chk("fwd_id_ready", id_ready, 1);
        tick();
        chk("fwd_exmem_valid", ex_valid, 1);
        chk("fwd_exmem_a", ex_a, 8'h22);
        chk("fwd_exmem_b", ex_b, 8'h44);
        chk("fwd_exmem_rd", ex_rd, 10);
        chk("fwd_exmem_op", ex_alu_op, 2);
        chk("fwd_exmem_rw", ex_reg_write, 1);
        exmem_reg_write = 1'b0;
        tick();
        chk("fwd_memwb_a", ex_a, 8'h33);
        memwb_reg_write = 1'b0;
        tick();
        chk("fwd_rf_a", ex_a, 8'h11);
        // Operand b forwarded from MEM/WB while a reads the register file
        instr(5'd1, 5'd2, 5'd11, 1'b1, 1'b1, 8'h0A, 8'h0B, 1'b1, 1'b0, 4'h3);
        memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_result = 8'h7E;
        tick();
        chk("fwd_b_memwb_a", ex_a, 8'h0A);
        chk("fwd_b_memwb_b", ex_b, 8'h7E);
        clear_bypass();

        // Register 31: never forwarded, never a hazard
        instr(5'd0, 5'd0, 5'd31, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h1);
        tick();
        chk("r31_load_held", {ex_valid, ex_mem_read, ex_rd}, {1'b1, 1'b1, 5'd31});
        instr(5'd31, 5'd31, 5'd12, 1'b1, 1'b1, 8'h77, 8'h78, 1'b1, 1'b0, 4'h4);
        exmem_reg_write = 1'b1; exmem_rd = 5'd31; exmem_result = 8'hAA;
        settle();
        chk("r31_no_hazard", id_ready, 1);
        tick();
        chk("r31_ex_a", ex_a, 8'h00);
        chk("r31_ex_b", ex_b, 8'h00);
        chk("r31_ex_valid", ex_valid, 1);
        clear_bypass();

        // Load-use: two bubbles, then MEM/WB data forwarded
        instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h1);
        tick();
        chk("lu_load_in_ex", {ex_valid, ex_mem_read, ex_rd}, {1'b1, 1'b1, 5'd5});
        instr(5'd5, 5'd6, 5'd13, 1'b1, 1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 4'h5);
        settle();
        chk("lu_stall1_id_ready", id_ready, 0);
        tick();
        chk("lu_bubble1", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);
        exmem_reg_write = 1'b1; exmem_mem_read = 1'b1; exmem_rd = 5'd5; exmem_result = 8'h99;
        settle();
        chk("lu_stall2_id_ready", id_ready, 0);
        tick();
        chk("lu_bubble2", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);
        clear_bypass();
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 8'h5C;
        settle();
        chk("lu_release_id_ready", id_ready, 1);
        tick();
        chk("lu_ex_valid", ex_valid, 1);
        chk("lu_ex_a", ex_a, 8'h5C);
        chk("lu_ex_rd", ex_rd, 13);
        clear_bypass();

        // Same load followed by an instruction that does not consume rs
        instr(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h1);
        tick();
        instr(5'd5, 5'd6, 5'd14, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 4'h6);
        settle();
        chk("lu_unused_id_ready", id_ready, 1);
        tick();
        chk("lu_unused_ex_valid", ex_valid, 1);
        chk("lu_unused_ex_a", ex_a, 8'h12);

        // Idle decode inserts a bubble
        id_valid = 1'b0;
        tick();
        chk("idle_bubble", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);

        // Backpressure: EX holds, decode inputs change underneath
        instr(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 8'hA1, 8'hB2, 1'b1, 1'b0, 4'h9);
        tick();
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr(5'(i + 1), 5'(i + 2), 5'(i + 20), 1'b1, 1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 1'b0, 1'b1, 4'(i));
            settle();
            chk("bp_id_ready", id_ready, 0);
            tick();
            chk("bp_hold", {ex_valid, ex_a, ex_b, ex_rd, ex_reg_write, ex_mem_read, ex_alu_op},
                {1'b1, 8'hA1, 8'hB2, 5'd7, 1'b1, 1'b0, 4'h9});
        end
        ex_ready = 1'b1;
        instr(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 8'hC3, 8'hD5, 1'b1, 1'b0, 4'hA);
        settle();
        chk("bp_release_id_ready", id_ready, 1);
        tick();
        chk("bp_capture", {ex_valid, ex_a, ex_b, ex_rd, ex_alu_op}, {1'b1, 8'hC3, 8'hD5, 5'd8, 4'hA});

        // Flush beats hold; decode instruction is taken the cycle after
        ex_ready = 1'b0; flush = 1'b1;
        instr(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 8'hD4, 8'hE6, 1'b1, 1'b0, 4'hB);
        settle();
        chk("flush_id_ready", id_ready, 0);
        tick();
        chk("flush_ex", {ex_valid, ex_reg_write, ex_mem_read}, 3'b000);
        flush = 1'b0;
        settle();
        chk("post_flush_id_ready", id_ready, 1);
        tick();
        chk("post_flush_capture", {ex_valid, ex_a, ex_rd}, {1'b1, 8'hD4, 5'd9});
        ex_ready = 1'b1;

        // Reset during a load-use stall clears everything
        instr(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h1);
        tick();
        instr(5'd4, 5'd0, 5'd15, 1'b1, 1'b0, 8'h44, 8'h00, 1'b1, 1'b0, 4'h7);
        settle();
        chk("rst_stall_id_ready", id_ready, 0);
        rst = 1'b1;
        tick();
        chk("rst_stall_ex", {ex_valid, ex_mem_read, ex_rd}, 0);
        rst = 1'b0;
        settle();
        chk("rst_stall_release", id_ready, 1);
        tick();
        chk("rst_stall_capture", {ex_valid, ex_a, ex_rd}, {1'b1, 8'h44, 5'd15});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
